// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, complex sample type and pack/unpack helpers for the FFT datapath
package fft_pkg;

  localparam int N    = 64;
  localparam int HALF = N / 2;
  localparam int DW   = 17;
  localparam int CW   = 2 * DW;
  localparam int VW   = N * CW;

  // re sits in the upper half so a packed cpx_t matches the flat-vector layout
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cpx_t;

  function automatic cpx_t get_sample(input logic [VW-1:0] vec, input int idx);
    return cpx_t'(vec[idx*CW +: CW]);
  endfunction

  function automatic logic [VW-1:0] put_sample(input logic [VW-1:0] vec, input int idx,
                                               input cpx_t s);
    logic [VW-1:0] r;
    r = vec;
    r[idx*CW +: CW] = s;
    return r;
  endfunction

endpackage

// File: rtl/bf2_cell.sv
// rtl/bf2_cell.sv - combinational radix-2 add/subtract pair on one complex sample pair
module bf2_cell
  import fft_pkg::*;
(
  input  cpx_t a_i,
  input  cpx_t b_i,
  output cpx_t sum_o,
  output cpx_t diff_o
);

  // Results are kept modulo 2^DW, so the carry into bit DW is simply dropped.
  assign sum_o.re  = a_i.re + b_i.re;
  assign sum_o.im  = a_i.im + b_i.im;
  assign diff_o.re = a_i.re - b_i.re;
  assign diff_o.im = a_i.im - b_i.im;

endmodule

// File: rtl/butterfly64_stage.sv
// rtl/butterfly64_stage.sv - one fully parallel radix-2 DIF butterfly stage over a 64-point vector
module butterfly64_stage
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [VW-1:0] butterfly64_in,
  output logic          out_valid,
  output logic [VW-1:0] butterfly64_out
);

  cpx_t a_w    [HALF];
  cpx_t b_w    [HALF];
  cpx_t sum_w  [HALF];
  cpx_t diff_w [HALF];

  logic [VW-1:0] res_w;
  logic [VW-1:0] out_d;
  logic [VW-1:0] out_q;
  logic          valid_q;

  for (genvar k = 0; k < HALF; k++) begin : g_cell
    assign a_w[k] = get_sample(butterfly64_in, k);
    assign b_w[k] = get_sample(butterfly64_in, k + HALF);

    bf2_cell u_cell (
      .a_i    (a_w[k]),
      .b_i    (b_w[k]),
      .sum_o  (sum_w[k]),
      .diff_o (diff_w[k])
    );
  end

  always_comb begin
    res_w = '0;
    for (int k = 0; k < HALF; k++) begin
      res_w = put_sample(res_w, k, sum_w[k]);
      res_w = put_sample(res_w, k + HALF, diff_w[k]);
    end
  end

  // Idle cycles keep the last result so stray input data never reaches the output.
  assign out_d = in_valid ? res_w : out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= in_valid;
    end
  end

  assign out_valid       = valid_q;
  assign butterfly64_out = out_q;

endmodule

// File: tb/tb_butterfly64_stage.sv
// tb/tb_butterfly64_stage.sv - scoreboard bench for butterfly64_stage with directed vectors
module tb_butterfly64_stage;

  localparam int VW = 2176;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [VW-1:0] din;
  logic          out_valid;
  logic [VW-1:0] dout;

  int checks;
  int errors;
  int cyc;

  logic [VW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  butterfly64_stage dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .butterfly64_in  (din),
    .out_valid       (out_valid),
    .butterfly64_out (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [VW-1:0] put(input logic [VW-1:0] v, input int i, input int re,
                                        input int im);
    logic [VW-1:0] r;
    r = v;
    r[i*34+17 +: 17] = re[16:0];
    r[i*34 +: 17]    = im[16:0];
    return r;
  endfunction

  task automatic chk_vec(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
    int idx;
    checks++;
    if (got !== want) begin
      errors++;
      idx = -1;
      for (int i = 63; i >= 0; i--)
        if (got[i*34 +: 34] !== want[i*34 +: 34]) idx = i;
      $display("FAIL %s: first bad sample %0d got %h want %h", name, idx,
               got[idx*34 +: 34], want[idx*34 +: 34]);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic rand_din();
    for (int i = 0; i < VW / 32; i++) din[i*32 +: 32] = $urandom;
  endtask

  // Called just after a rising edge; the vector is sampled on the next one.
  task automatic send(input logic [VW-1:0] v, input logic [VW-1:0] e);
    in_valid = 1'b1;
    din      = v;
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got out_valid 1 want no output at cycle %0d", cyc);
      end else begin
        chk_vec("stream_data", dout, exp_q.pop_front());
        chk_int("stream_latency", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  logic [VW-1:0] v;
  logic [VW-1:0] e;
  logic [VW-1:0] last_e;

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b1;
    rand_din();

    // reset with a vector presented: it must be dropped
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_int("reset_valid", int'(out_valid), 0);
    chk_vec("reset_data", dout, '0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    rand_din();
    repeat (2) @(negedge clk);
    chk_int("post_reset_valid", int'(out_valid), 0);
    chk_vec("post_reset_data", dout, '0);
    @(posedge clk);
    #1;

    // impulse
    v = put('0, 0, 100, -50);
    e = put('0, 0, 100, -50);
    e = put(e, 32, 100, -50);
    send(v, e);

    // single pair
    v = put('0, 5, 300, 7);
    v = put(v, 37, -100, 10);
    e = put('0, 5, 200, 17);
    e = put(e, 37, 400, -3);
    send(v, e);

    // wrap and headroom boundaries
    v = put('0, 0, 65535, 0);
    v = put(v, 32, 1, 0);
    v = put(v, 1, -65536, 0);
    v = put(v, 33, 1, 0);
    v = put(v, 2, 32767, 0);
    v = put(v, 34, 32767, 0);
    e = put('0, 0, -65536, 0);
    e = put(e, 32, 65534, 0);
    e = put(e, 1, -65535, 0);
    e = put(e, 33, 65535, 0);
    e = put(e, 2, 65534, 0);
    send(v, e);

    // three back-to-back streaming vectors
    v = '0;
    e = '0;
    for (int i = 0; i < 64; i++) v = put(v, i, i, -i);
    for (int k = 0; k < 32; k++) begin
      e = put(e, k, 2*k + 32, -(2*k + 32));
      e = put(e, k + 32, -32, 32);
    end
    send(v, e);

    v = '0;
    e = '0;
    for (int i = 0; i < 64; i++) v = put(v, i, 1, 0);
    for (int k = 0; k < 32; k++) e = put(e, k, 2, 0);
    send(v, e);

    v = '0;
    e = '0;
    for (int k = 0; k < 32; k++) begin
      v = put(v, k, -65536, 5);
      v = put(v, k + 32, 0, 5);
      e = put(e, k, -65536, 10);
      e = put(e, k + 32, -65536, 0);
    end
    send(v, e);
    last_e   = e;
    in_valid = 1'b0;
    rand_din();

    // hold: idle cycles with changing data
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      rand_din();
      if (n == 2) din = 'x;
      @(negedge clk);
      chk_int("hold_valid", int'(out_valid), 0);
      chk_vec("hold_data", dout, last_e);
    end
    @(posedge clk);
    #1;

    // reset mid-stream clears output and drops the concurrent vector
    v = put('0, 5, 300, 7);
    v = put(v, 37, -100, 10);
    e = put('0, 5, 200, 17);
    e = put(e, 37, 400, -3);
    send(v, e);
    rst      = 1'b1;
    in_valid = 1'b1;
    rand_din();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk_int("midreset_valid", int'(out_valid), 0);
    chk_vec("midreset_data", dout, '0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_int("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/butterfly64_stage.md
Name: butterfly64_stage

Overview:
- One radix-2 decimation-in-frequency butterfly stage across a 64-point complex vector, used as a stage of the variable-point FFT datapath.
- Pairs element k with element k+32 (k = 0..31) and produces sum and difference outputs.
- Twiddle multiplication is done by a downstream block, not here.
- Fully parallel: one 64-sample vector per clock, outputs registered.

Parameters:
- N, 64, number of complex points per vector (fixed, even; half-span N/2 = 32).
- DW, 17, bit width of each real and each imaginary component (two's complement).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies butterfly64_in on this clock edge.
- butterfly64_in  input  N*2*DW (2176)  packed input vector; sample i occupies bits [i*34+33 : i*34]; within a sample, real = [33:17], imag = [16:0].
- out_valid  output  1  qualifies butterfly64_out.
- butterfly64_out  output  N*2*DW (2176)  packed output vector, same packing as the input.

Behaviour:
- Notation: x[i] is input sample i and y[i] is output sample i. Real and imaginary parts are treated independently as signed DW-bit values.
- For k = 0..31:
  - y[k] = x[k] + x[k+32]
  - y[k+32] = x[k] - x[k+32]
- Width rule: each result is computed at DW+1 bits and the low DW bits are kept, so overflow wraps modulo 2^17. There is no scaling and no saturation; headroom is the caller's responsibility.
- Latency: exactly 1 clock.
  - On a rising edge with in_valid=1, the output register loads the results and out_valid becomes 1 on the following cycle.
  - On an edge with in_valid=0, out_valid becomes 0 and butterfly64_out holds its previous value.
- Back-to-back: a new vector may be accepted every cycle. There is no backpressure and no ready signal.
- Reset: on an edge where rst=1, butterfly64_out becomes all zeros and out_valid becomes 0. This takes priority over in_valid.
  - A vector presented in the same cycle as reset is dropped.
  - The first valid output after reset release appears 1 cycle after the first in_valid=1.
- Sign-extension boundaries:
  - Most-negative operand (-65536): its sign extension must be correct.
  - 32767 + 32767 = 65534 fits in 17 bits.
  - 65535 + 1 wraps to -65536.
  - -65536 - 1 wraps to 65535.
- X/unknown inputs when in_valid=0 must not disturb the held output.

Decomposition:
- Shared package fft_pkg holds:
  - constants DW=17 and CW=34 (complex sample width);
  - a complex sample typedef with re and im fields of signed [DW-1:0];
  - helper functions to unpack and pack sample i from a flat vector.
- One natural sub-module, bf2_cell: a combinational single complex add/subtract pair (a+b, a-b, wrapping).
  - Instantiated 32 times via generate.
  - The top holds the registers and the valid flop.

Test Plan:
1. Reset: hold rst=1 with in_valid=1 and random data -> out_valid=0 and butterfly64_out=0. Release rst -> outputs stay 0 until the first valid input.
2. Impulse: x[0]=(re 100, im -50), all others 0, in_valid=1 -> next cycle out_valid=1, y[0]=(100,-50), y[32]=(100,-50), all others 0.
3. Pair arithmetic: x[5]=(300,7), x[37]=(-100,10) -> y[5]=(200,17), y[37]=(400,-3). Every other y is 0 when all other x are 0.
4. Overflow wrap: x[0].re=65535, x[32].re=1 -> y[0].re=-65536 and y[32].re=65534. Also x[1].re=-65536, x[33].re=1 -> y[33].re=65535.
5. Streaming: 3 back-to-back vectors with random data (x[i].re=i, x[i].im=-i for the first) -> each output appears exactly 1 cycle later in order. For the first vector, y[k].re=2k+32, y[k+32].re=-32.
6. Hold: in_valid drops to 0 with changing input data -> out_valid=0 and butterfly64_out unchanged. Asserting rst mid-stream clears both on the next edge.
